// File: rtl/stream_mux_pkg.sv
// Shared defaults, data word type and index helper for the round-robin stream mux.
package stream_mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_N     = 4;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // (idx+1) mod n without a divider; idx is always < n at the call sites
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter with force-select override.
// STREAM_MUX_RR_EN selects round-robin search from ptr; otherwise fixed priority from 0.
import stream_mux_pkg::*;

module rr_arbiter #(
    parameter  int unsigned N    = DEFAULT_N,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            force_en,
    input  logic [SELW-1:0] force_sel,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    int unsigned start;
    int unsigned idx;

`ifdef STREAM_MUX_RR_EN
    assign start = 32'(ptr);
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign start      = 0;
`endif

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (force_en) begin
            // an out-of-range or idle forced channel yields no grant at all
            if (32'(force_sel) < N) begin
                grant       = force_sel;
                grant_valid = req[force_sel];
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = start + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_valid && req[idx]) begin
                    grant       = SELW'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with registered output and built-in arbiter.
// Define STREAM_MUX_RR_EN for round-robin arbitration; default is fixed priority.
import stream_mux_pkg::*;

module stream_mux_rr #(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned N     = DEFAULT_N,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0][WIDTH-1:0] in_data,
    input  logic [N-1:0]            in_valid,
    output logic [N-1:0]            in_ready,
    input  logic                    force_en,
    input  logic [SELW-1:0]         force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SELW-1:0]         out_sel
);

    logic            load;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic [SELW-1:0] arb_ptr;

    assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0] ptr;

    // force-mode transfers leave the rotation where arbiter mode last put it
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (load && grant_valid && !force_en) begin
            ptr <= SELW'(next_idx(32'(grant), N));
        end
    end

    assign arb_ptr = ptr;
`else
    assign arb_ptr = '0;
`endif

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req         (in_valid),
        .ptr         (arb_ptr),
        .force_en    (force_en),
        .force_sel   (force_sel),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        in_ready = '0;
        if (!reset && load && grant_valid) begin
            in_ready[grant] = in_valid[grant];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_data  <= in_data[grant];
                out_sel   <= grant;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
